// File: rtl/blink_rate_controller_if.sv
// ---------------------------------------------------------------------------
// blink_rate_controller_if
//   Board-side signal bundle for blink_rate_controller.
//   master : drives the raw buttons, observes the LED/tick/status outputs
//   slave  : the controller itself
// Signals:
//   BTN_SPEED  raw speed button, active-low, asynchronous to CLK
//   BTN_PAUSE  raw pause button, active-low, asynchronous to CLK
//   LED[3:0]   pattern output
//   TICK       one-cycle enable pulse (registered)
//   RATE_SEL   current rate index (registered)
//   RUNNING    1 = RUN, 0 = PAUSE
// ---------------------------------------------------------------------------
interface blink_rate_controller_if;
    logic       BTN_SPEED;
    logic       BTN_PAUSE;
    logic [3:0] LED;
    logic       TICK;
    logic [1:0] RATE_SEL;
    logic       RUNNING;

    modport master (
        output BTN_SPEED, BTN_PAUSE,
        input  LED, TICK, RATE_SEL, RUNNING
    );

    modport slave (
        input  BTN_SPEED, BTN_PAUSE,
        output LED, TICK, RATE_SEL, RUNNING
    );
endinterface

// File: rtl/blink_rate_controller.sv
// ---------------------------------------------------------------------------
// blink_rate_controller
//   Shared prescaler + LED pattern sequencer. A debounced SPEED button cycles
//   through a 4-entry divisor table; a debounced PAUSE button toggles between
//   RUN and PAUSE. Each prescaler tick advances the 4-LED pattern.
// Ports:
//   CLK    system clock
//   RESET  asynchronous reset, active-low
//   bus    blink_rate_controller_if.slave (buttons in, LED/TICK/RATE_SEL/
//          RUNNING out)
// Build option:
//   BLINK_BOUNCE_EN  defined   -> LED ping-pongs 0001..1000..0001
//                    undefined -> LED rotates left
// ---------------------------------------------------------------------------
module blink_rate_controller #(
    parameter int CNT_W      = 26,
    parameter int DIV0       = 1000000,
    parameter int DIV1       = 500000,
    parameter int DIV2       = 250000,
    parameter int DIV3       = 125000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic                         CLK,
    input  logic                         RESET,
    blink_rate_controller_if.slave       bus
);

    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Every divisor must be >= 1 and representable in CNT_W bits.
    localparam bit DIV_OK = (DIV0 >= 1) && ((DIV0 >> CNT_W) == 0) &&
                            (DIV1 >= 1) && ((DIV1 >> CNT_W) == 0) &&
                            (DIV2 >= 1) && ((DIV2 >> CNT_W) == 0) &&
                            (DIV3 >= 1) && ((DIV3 >> CNT_W) == 0);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Button synchronisers and debouncers; bit 0 = SPEED, bit 1 = PAUSE
    // -----------------------------------------------------------------------
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [DEB_W-1:0] dcnt [2];
    logic [1:0]       press;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= {bus.BTN_PAUSE, bus.BTN_SPEED};
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    // DEB_CYCLES-th consecutive differing sample: accept it
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Press = debounced 1->0; release produces nothing.
    assign press = deb_d & ~deb;

    logic speed_ev;
    logic pause_ev;
    assign speed_ev = press[0];
    assign pause_ev = press[1];

    // -----------------------------------------------------------------------
    // Run/pause FSM, prescaler, rate select and LED pattern
    // -----------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_m1;
    logic             tick_q;
    logic             running_q;
    logic [1:0]       rate_q;
    logic [3:0]       led_q;
`ifdef BLINK_BOUNCE_EN
    logic             dir_right;
`endif

    always_comb begin
        state_nxt = state;
        if (pause_ev) begin
            state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    always_comb begin
        div_m1 = '0;
        case (rate_q)
            2'd0:    div_m1 = CNT_W'(DIV0 - 1);
            2'd1:    div_m1 = CNT_W'(DIV1 - 1);
            2'd2:    div_m1 = CNT_W'(DIV2 - 1);
            default: div_m1 = CNT_W'(DIV3 - 1);
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_RUN;
            running_q <= 1'b1;
            count     <= '0;
            tick_q    <= 1'b0;
            rate_q    <= '0;
            led_q     <= 4'b0001;
`ifdef BLINK_BOUNCE_EN
            dir_right <= 1'b0;
`endif
        end else begin
            assert (DIV_OK) else $error("blink_rate_controller: divisor out of range for CNT_W");

            state     <= state_nxt;
            running_q <= (state_nxt == ST_RUN);

            // LED follows the registered tick, so it lags TICK by one edge.
            if (tick_q) begin
`ifdef BLINK_BOUNCE_EN
                if (dir_right) begin
                    led_q <= led_q >> 1;
                    if (led_q == 4'b0010) dir_right <= 1'b0;
                end else begin
                    led_q <= led_q << 1;
                    if (led_q == 4'b0100) dir_right <= 1'b1;
                end
`else
                led_q <= {led_q[2:0], led_q[3]};
`endif
            end

            // Prescaler is gated by the post-toggle state: the edge that
            // enters PAUSE already holds the count, the edge that leaves it
            // already counts. A SPEED press overrides terminal count.
            if (speed_ev) begin
                rate_q <= rate_q + 2'd1;
                count  <= '0;
                tick_q <= 1'b0;
            end else if (state_nxt == ST_RUN) begin
                if (count == div_m1) begin
                    count  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    count  <= count + 1'b1;
                    tick_q <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end
        end
    end

    assign bus.LED      = led_q;
    assign bus.TICK     = tick_q;
    assign bus.RATE_SEL = rate_q;
    assign bus.RUNNING  = running_q;

endmodule

// File: tb/tb_blink_rate_controller.sv
// ---------------------------------------------------------------------------
// tb_blink_rate_controller
//   Self-checking bench for blink_rate_controller with small divisors
//   (8/4/2/1) and DEB_CYCLES = 4. A cycle model pushes expected outputs into
//   a scoreboard queue on each rising edge; they are popped and compared on
//   the following falling edge. A vector table and hand-written sequences
//   check phase results, press latency, tick spacing and async reset.
// ---------------------------------------------------------------------------
module tb_blink_rate_controller;

    localparam int CNT_W = 4;
    localparam int DIV0  = 8;
    localparam int DIV1  = 4;
    localparam int DIV2  = 2;
    localparam int DIV3  = 1;
    localparam int DEB   = 4;
    localparam int NVEC  = 17;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    blink_rate_controller_if bus ();

    blink_rate_controller #(
        .CNT_W      (CNT_W),
        .DIV0       (DIV0),
        .DIV1       (DIV1),
        .DIV2       (DIV2),
        .DIV3       (DIV3),
        .DEB_CYCLES (DEB)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model + scoreboard
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [3:0] led;
        logic       tick;
        logic [1:0] rate;
        logic       run;
    } obs_t;

    obs_t sb[$];
    obs_t sb_exp;

    logic [1:0]  m_s1, m_s2, m_deb, m_debd;
    int unsigned m_dcnt [2];
    int unsigned m_cnt;
    logic        m_tick, m_run;
    logic [1:0]  m_rate;
    logic [3:0]  m_led;
    int unsigned m_pos;
    logic [3:0]  bounce_tbl [6];

    function automatic int unsigned divisor(input logic [1:0] r);
        case (r)
            2'd0:    return DIV0;
            2'd1:    return DIV1;
            2'd2:    return DIV2;
            default: return DIV3;
        endcase
    endfunction

    task automatic m_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_debd = 2'b11;
        m_dcnt[0] = 0; m_dcnt[1] = 0;
        m_cnt = 0; m_tick = 1'b0; m_run = 1'b1; m_rate = 2'd0;
        m_led = 4'b0001; m_pos = 0;
    endtask

    task automatic m_step();
        logic sp_ev, pa_ev, nxt_run;
        sp_ev = m_debd[0] && !m_deb[0];
        pa_ev = m_debd[1] && !m_deb[1];
        m_debd = m_deb;
        for (int b = 0; b < 2; b++) begin
            if (m_s2[b] != m_deb[b]) begin
                m_dcnt[b]++;
                if (m_dcnt[b] == DEB) begin
                    m_deb[b]  = m_s2[b];
                    m_dcnt[b] = 0;
                end
            end else begin
                m_dcnt[b] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = {bus.BTN_PAUSE, bus.BTN_SPEED};

        nxt_run = m_run ^ pa_ev;
        if (m_tick) begin
`ifdef BLINK_BOUNCE_EN
            m_pos = (m_pos + 1) % 6;
            m_led = bounce_tbl[m_pos];
`else
            m_led = {m_led[2:0], m_led[3]};
`endif
        end
        if (sp_ev) begin
            m_rate = m_rate + 2'd1;
            m_cnt  = 0;
            m_tick = 1'b0;
        end else if (nxt_run) begin
            if (m_cnt == divisor(m_rate) - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        m_run = nxt_run;
    endtask

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_reset();
            sb.delete();
        end else begin
            m_step();
            sb.push_back('{led: m_led, tick: m_tick, rate: m_rate, run: m_run});
        end
    end

    always @(negedge CLK) begin
        if (RESET && sb.size() > 0) begin
            sb_exp = sb.pop_front();
            check("sb_led",  bus.LED,      sb_exp.led);
            check("sb_tick", bus.TICK,     sb_exp.tick);
            check("sb_rate", bus.RATE_SEL, sb_exp.rate);
            check("sb_run",  bus.RUNNING,  sb_exp.run);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    typedef struct {
        logic        spd;
        logic        pau;
        int unsigned cyc;
        logic [1:0]  rate;
        logic        run;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [3:0]  exp_led [8];
    logic [3:0]  prev_led;
    int unsigned waited;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bounce_tbl[0] = 4'b0001; bounce_tbl[1] = 4'b0010; bounce_tbl[2] = 4'b0100;
        bounce_tbl[3] = 4'b1000; bounce_tbl[4] = 4'b0100; bounce_tbl[5] = 4'b0010;
`ifdef BLINK_BOUNCE_EN
        exp_led[0] = 4'b0010; exp_led[1] = 4'b0100; exp_led[2] = 4'b1000; exp_led[3] = 4'b0100;
        exp_led[4] = 4'b0010; exp_led[5] = 4'b0001; exp_led[6] = 4'b0010; exp_led[7] = 4'b0100;
`else
        exp_led[0] = 4'b0010; exp_led[1] = 4'b0100; exp_led[2] = 4'b1000; exp_led[3] = 4'b0001;
        exp_led[4] = 4'b0010; exp_led[5] = 4'b0100; exp_led[6] = 4'b1000; exp_led[7] = 4'b0001;
`endif
        //          spd   pau   cyc  rate  run
        vecs[0]  = '{1'b1, 1'b1, 30, 2'd0, 1'b1};  // idle
        vecs[1]  = '{1'b0, 1'b1, 20, 2'd1, 1'b1};  // speed press 1
        vecs[2]  = '{1'b1, 1'b1, 20, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 20, 2'd2, 1'b1};  // speed press 2
        vecs[4]  = '{1'b1, 1'b1, 20, 2'd2, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 20, 2'd3, 1'b1};  // speed press 3
        vecs[6]  = '{1'b1, 1'b1, 20, 2'd3, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 20, 2'd0, 1'b1};  // speed press 4 wraps
        vecs[8]  = '{1'b1, 1'b1, 20, 2'd0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1,  3, 2'd0, 1'b1};  // 3-cycle glitch
        vecs[10] = '{1'b1, 1'b1, 20, 2'd0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 20, 2'd0, 1'b0};  // pause
        vecs[12] = '{1'b1, 1'b1, 50, 2'd0, 1'b0};  // frozen
        vecs[13] = '{1'b1, 1'b0, 20, 2'd0, 1'b1};  // resume
        vecs[14] = '{1'b1, 1'b1, 20, 2'd0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 20, 2'd1, 1'b0};  // speed + pause together
        vecs[16] = '{1'b1, 1'b1, 20, 2'd1, 1'b0};

        bus.BTN_SPEED = 1'b1;
        bus.BTN_PAUSE = 1'b1;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_led",  bus.LED,      4'b0001);
        check("rst_tick", bus.TICK,     0);
        check("rst_rate", bus.RATE_SEL, 0);
        check("rst_run",  bus.RUNNING,  1);
        RESET = 1'b1;

        // LED pattern over 8 ticks at rate 0, with 8-cycle spacing
        prev_led = bus.LED;
        for (int k = 0; k < 8; k++) begin
            waited = 0;
            do begin
                @(negedge CLK);
                waited++;
            end while (bus.LED == prev_led && waited < 20);
            check($sformatf("led_step%0d", k), bus.LED, exp_led[k]);
            if (k > 0) check($sformatf("led_spacing%0d", k), waited, DIV0);
            prev_led = bus.LED;
        end

        // Phase table
        for (int i = 0; i < NVEC; i++) begin
            bus.BTN_SPEED = vecs[i].spd;
            bus.BTN_PAUSE = vecs[i].pau;
            repeat (vecs[i].cyc) @(negedge CLK);
            check($sformatf("vec%0d_rate", i), bus.RATE_SEL, vecs[i].rate);
            check($sformatf("vec%0d_run", i),  bus.RUNNING,  vecs[i].run);
        end

        // Back to RUN
        bus.BTN_PAUSE = 1'b0;
        repeat (20) @(negedge CLK);
        check("resume_run", bus.RUNNING, 1);
        bus.BTN_PAUSE = 1'b1;
        repeat (20) @(negedge CLK);

        // Press latency: rate changes on the 7th edge after the raw edge
        bus.BTN_SPEED = 1'b0;
        repeat (6) @(negedge CLK);
        check("lat_edge6", bus.RATE_SEL, 1);
        @(negedge CLK);
        check("lat_edge7", bus.RATE_SEL, 2);
        repeat (13) @(negedge CLK);
        bus.BTN_SPEED = 1'b1;
        repeat (20) @(negedge CLK);

        // Rate 3 (divisor 1): TICK held high
        bus.BTN_SPEED = 1'b0;
        repeat (20) @(negedge CLK);
        bus.BTN_SPEED = 1'b1;
        repeat (20) @(negedge CLK);
        check("rate3", bus.RATE_SEL, 3);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check($sformatf("tick_high%0d", k), bus.TICK, 1);
        end

        // Asynchronous reset between clock edges
        #2;
        RESET = 1'b0;
        #1;
        check("arst_led",  bus.LED,      4'b0001);
        check("arst_tick", bus.TICK,     0);
        check("arst_rate", bus.RATE_SEL, 0);
        check("arst_run",  bus.RUNNING,  1);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (20) @(negedge CLK);
        check("post_rate", bus.RATE_SEL, 0);
        check("post_run",  bus.RUNNING,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
